// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode types and constants.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory read port plus the decode-facing handshake.
interface instr_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        done_out;

  modport master (
    output imem_req, imem_addr, instr, pc_out, done_out,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc_out, done_out,
    output imem_rdata, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_sync_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two, at least 2.
module instr_fetch_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FullCnt);
    do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    do_push = push && (!full || do_pop);
    count   = count_q;
    head    = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, buffers words for decode.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] Credits = (CntW + 1)'(DEPTH);

  logic [31:0]     fetch_pc_q;
  logic [31:0]     fetch_pc_d;
  logic            inflight_q;
  logic            discard_q;

  logic [CntW-1:0] count;
  logic            empty;
  logic            full;
  logic [CntW:0]   credits_used;
  logic            req;
  logic            push;
  logic            pop;
  logic            done;
  fetch_entry_t    wdata;
  fetch_entry_t    head;

  always_comb begin
    credits_used = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
    req          = !rst && !bus.redirect && (credits_used < Credits);
    done         = !empty && !bus.redirect;
    pop          = done && !bus.stall;
    push         = inflight_q && !discard_q && !bus.redirect && (!full || pop);
    // fetch_pc_q already advanced past the in-flight word, so it equals that word's PC+4.
    wdata.instr  = bus.imem_rdata;
    wdata.pc4    = fetch_pc_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect) begin
      fetch_pc_d = align_word(bus.redirect_pc);
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= align_word(RESET_PC);
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= req;
      discard_q  <= bus.redirect;
    end
  end

  instr_fetch_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (wdata),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.done_out  = done;
  assign bus.instr     = empty ? NOP_INSTR : head.instr;
  assign bus.pc_out    = empty ? 32'h0 : head.pc4;

endmodule
